// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_arb_pkg
// Brief  : Shared types and constants for the UART transmit arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    SEND    = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4
  } arb_state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Header byte before resizing to the datapath width: tag nibble, index nibble.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    return {HDR_TAG, idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin selector; first set request at or
//          after the pointer, wrapping modulo NUM_REQ.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int pos;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_W'(pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Packet-granular round-robin sharing of one UART transmitter
//          between NUM_REQ byte-stream requesters.
// Config : define UART_ARB_HDR_EN to prefix each grant with a header byte.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int MAX_PKT_BYTES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           uart_start,
  output logic [DATA_BITS-1:0]           uart_data,
  input  logic                           uart_ready,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_PKT_BYTES);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 fin_q, fin_d;
  logic [DATA_BITS-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_BITS-1:0] sel_data;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 send_fire;
  logic                 hdr_fire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the granted requester's lane is ever looked at.
  assign sel_valid = req_valid[idx_q];
  assign sel_last  = req_last[idx_q];
  assign sel_data  = req_data[int'(idx_q) * DATA_BITS +: DATA_BITS];
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign send_fire = (state_q == SEND) && uart_ready && sel_valid;

`ifdef UART_ARB_HDR_EN
  logic [7:0]           hdr_raw;
  logic [DATA_BITS-1:0] hdr_data;
  assign hdr_raw  = hdr_byte(4'(idx_q));
  assign hdr_data = DATA_BITS'(hdr_raw);
  assign hdr_fire = (state_q == HDR) && uart_ready;
`else
  assign hdr_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
`ifdef UART_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = SEND;
`endif
        end
      end
`ifdef UART_ARB_HDR_EN
      HDR: begin
        if (uart_ready) begin
          state_d = WAIT_LO;
        end
      end
`endif
      SEND: begin
        if (send_fire) begin
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!uart_ready) begin
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (uart_ready) begin
          state_d = fin_q ? IDLE : SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
    data_d  = data_q;
    if ((state_q == IDLE) && pick_any) begin
      grant_d = pick_gnt;
      idx_d   = pick_idx;
      fin_d   = 1'b0;
    end
    if (send_fire) begin
      data_d = sel_data;
      cnt_d  = cnt_inc;
      fin_d  = sel_last || (cnt_inc == C_MAX_CNT);
    end
`ifdef UART_ARB_HDR_EN
    if (hdr_fire) begin
      data_d = hdr_data;
    end
`endif
    // Release after the transmitter has fully taken the closing byte.
    if ((state_q == WAIT_HI) && uart_ready && fin_q) begin
      grant_d = '0;
      ptr_d   = (idx_q == C_LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      cnt_d   = '0;
    end
  end

  always_comb begin
    uart_start = send_fire || hdr_fire;
    uart_data  = data_d;
    req_ready  = send_fire ? grant_q : '0;
    grant      = grant_q;
    busy       = (state_q != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Self-checking bench: reset/arbitration table, directed packet
//          scenarios and randomized traffic against a transaction-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;

  typedef struct packed {logic last; logic [7:0] data;} ent_t;
  typedef struct packed {logic [3:0] idx; logic [7:0] data;} xfer_t;
  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_grant;
    logic         exp_busy;
    logic [7:0]   exp_data;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            uart_start;
  logic [DW-1:0]   uart_data;
  logic            uart_ready = 1'b1;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .DATA_BITS     (DW),
    .MAX_PKT_BYTES (MAXB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .grant      (grant),
    .uart_start (uart_start),
    .uart_data  (uart_data),
    .uart_ready (uart_ready),
    .busy       (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Transmitter: takes start while ready, then holds ready low frame_len cycles.
  int tx_cnt    = 0;
  int frame_len = 10;
  always @(posedge clk) begin
    if (tx_cnt > 0) begin
      if (tx_cnt == 1) uart_ready <= 1'b1;
      tx_cnt <= tx_cnt - 1;
    end else if (uart_ready && uart_start) begin
      uart_ready <= 1'b0;
      tx_cnt     <= frame_len;
    end
  end

  function automatic logic [3:0] oh2i(input logic [N-1:0] v);
    logic [3:0] r = 4'hF;
    for (int i = 0; i < N; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  function automatic xfer_t mk(input int g, input logic [7:0] d);
    xfer_t x;
    x.idx  = 4'(g);
    x.data = d;
    return x;
  endfunction

  // Monitor
  xfer_t        obs[$];
  int           strobes      = 0;
  int           grant_events = 0;
  logic         prev_start   = 1'b0;
  logic [N-1:0] prev_grant   = '0;
  logic [N-1:0] acc_mask     = '0;

  always @(negedge clk) begin
    acc_mask = rst_n ? req_ready : '0;
    if (rst_n) begin
      if (uart_start) begin
        chk("start_while_tx_busy", 32'(uart_ready), 32'd1);
        chk("start_back_to_back", 32'(prev_start), 32'd0);
        obs.push_back(mk(int'(oh2i(grant)), uart_data));
      end
      if (req_ready != '0) begin
        chk("ready_equals_grant", 32'(req_ready), 32'(grant));
        chk("ready_with_start", 32'(uart_start), 32'd1);
        strobes++;
      end
      if (grant != '0 && prev_grant == '0) grant_events++;
    end
    prev_start = uart_start;
    prev_grant = grant;
  end

  // Requester driver: each lane presents the head of its byte queue.
  ent_t         rq[N][$];
  logic [N-1:0] hold   = '0;
  bit           drv_en = 1'b0;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]          = !hold[i];
        req_data[i*DW +: DW]  = rq[i][0].data;
        req_last[i]           = rq[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int i = 0; i < N; i++)
          if (acc_mask[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        refresh();
      end
    end
  end

  // Reference model: whole-packet round robin computed from queued traffic.
  xfer_t expq[$];
  int    exp_segs;
  int    exp_strobes;
  bit    exp_stuck;

  task automatic model();
    ent_t m[N][$];
    int   ptr = 0;
    for (int i = 0; i < N; i++) m[i] = rq[i];
    expq.delete();
    exp_segs = 0; exp_strobes = 0; exp_stuck = 0;
    forever begin
      int g = -1;
      int n = 0;
      bit fin = 0;
      for (int k = 0; k < N; k++)
        if (g < 0 && m[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
      if (g < 0) break;
      exp_segs++;
`ifdef UART_ARB_HDR_EN
      expq.push_back(mk(g, {4'hA, 4'(g)}));
`endif
      while (!fin && m[g].size() > 0) begin
        ent_t e = m[g].pop_front();
        expq.push_back(mk(g, e.data));
        n++;
        exp_strobes++;
        fin = e.last || (n == MAXB);
      end
      if (!fin) begin
        exp_stuck = 1;
        break;
      end
      ptr = (g + 1) % N;
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_and_check(input string nm);
    bit done = 0;
    model();
    obs.delete();
    strobes = 0;
    grant_events = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk);
      done = all_empty();
    end
    if (!done) chk({nm, "_timeout"}, 32'd1, 32'd0);
    repeat (frame_len + 10) @(posedge clk);
    @(negedge clk);
    chk({nm, "_xfer_count"}, 32'(obs.size()), 32'(expq.size()));
    for (int k = 0; k < obs.size() && k < expq.size(); k++)
      chk($sformatf("%s_xfer%0d", nm, k), 32'(obs[k]), 32'(expq[k]));
    chk({nm, "_strobes"}, 32'(strobes), 32'(exp_strobes));
    chk({nm, "_grants"}, 32'(grant_events), 32'(exp_segs));
    chk({nm, "_busy_end"}, 32'(busy), 32'(exp_stuck));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    hold = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push_pkt(input int r, input logic [7:0] d[$]);
    for (int b = 0; b < d.size(); b++) rq[r].push_back({b == d.size() - 1, d[b]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tbl[0] = '{4'b0001, 4'b0001, 1'b1, 8'h10};
    tbl[1] = '{4'b1010, 4'b0010, 1'b1, 8'h11};
    tbl[2] = '{4'b1100, 4'b0100, 1'b1, 8'h12};
    tbl[3] = '{4'b1000, 4'b1000, 1'b1, 8'h13};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 8'h00};
    tbl[5] = '{4'b1111, 4'b0001, 1'b1, 8'h10};

    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_start", 32'(uart_start), 32'd0);
    chk("reset_data", 32'(uart_data), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);

    // First-arbitration table from the reset pointer.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = tbl[t].valid;
      req_last  = '1;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_grant", t), 32'(grant), 32'(tbl[t].exp_grant));
      chk($sformatf("tbl%0d_busy", t), 32'(busy), 32'(tbl[t].exp_busy));
`ifndef UART_ARB_HDR_EN
      chk($sformatf("tbl%0d_req_ready", t), 32'(req_ready), 32'(tbl[t].exp_grant));
      chk($sformatf("tbl%0d_data", t), 32'(uart_data), 32'(tbl[t].exp_data));
`endif
      rst_n = 1'b0;
    end
    req_valid = '0;
    req_last  = '0;
    drv_en    = 1'b1;

    // Single two-byte packet.
    do_reset();
    frame_len = 10;
    push_pkt(0, '{8'h55, 8'h0F});
    run_and_check("single");

    // Fairness between two continuously valid requesters.
    do_reset();
    push_pkt(1, '{8'h11}); push_pkt(1, '{8'h12});
    push_pkt(3, '{8'h31}); push_pkt(3, '{8'h32});
    run_and_check("fair");

    // Atomicity across a long valid bubble.
    do_reset();
    push_pkt(0, '{8'hA1, 8'hA2, 8'hA3});
    push_pkt(2, '{8'hB1, 8'hB2});
    fork
      run_and_check("atomic");
      begin
        bit seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
          @(negedge clk);
          seen = req_ready[0];
        end
        chk("atomic_first_byte_seen", 32'(seen), 32'd1);
        hold[0] = 1'b1;
        repeat (20) @(negedge clk);
        chk("atomic_grant_during_gap", 32'(grant), 32'b0001);
        chk("atomic_busy_during_gap", 32'(busy), 32'd1);
        hold[0] = 1'b0;
      end
    join

    // Cap release: six bytes without last.
    do_reset();
    for (int b = 0; b < 6; b++) rq[2].push_back({1'b0, 8'(8'hC0 + b)});
    run_and_check("cap");
    chk("cap_grant_held", 32'(grant), 32'b0100);

    // Reset during WAIT_HI.
    do_reset();
    push_pkt(0, '{8'hD1, 8'hD2, 8'hD3});
    push_pkt(2, '{8'hE1});
    begin
      bit seen = 0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        seen = req_ready[0];
      end
      chk("rst_first_byte_seen", 32'(seen), 32'd1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    #1;
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_start", 32'(uart_start), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    push_pkt(1, '{8'h71});
    push_pkt(0, '{8'h70});
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("post_reset");
    chk("post_reset_first_owner", 32'(obs.size() > 0 ? obs[0].idx : 4'hF), 32'd0);

    // One byte from requester 3, with a header in front when enabled.
    do_reset();
    push_pkt(3, '{8'hC3});
    run_and_check("req3");
`ifdef UART_ARB_HDR_EN
    chk("hdr_byte", 32'(obs.size() > 0 ? obs[0].data : 8'h00), 32'hA3);
    chk("hdr_payload", 32'(obs.size() > 1 ? obs[1].data : 8'h00), 32'hC3);
`else
    chk("req3_payload", 32'(obs.size() > 0 ? obs[0].data : 8'h00), 32'hC3);
`endif

    // Randomized traffic.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      frame_len = $urandom_range(1, 8);
      for (int i = 0; i < N; i++) begin
        int np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) rq[i].push_back({b == len - 1, 8'($urandom)});
        end
      end
      run_and_check($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters, e.g. several test-harness reporters feeding one serial line.
- Round-robin arbitration at packet granularity: once a requester is granted, all its bytes go out back-to-back until its last flag or the MAX_PKT_BYTES cap.
- Drives the transmitter's start, data and ready interface. Transmitter: start is sampled only while ready=1, and ready drops on the clock edge after start is sampled.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_BITS, 8: byte width; must match the transmitter.
- MAX_PKT_BYTES, 16: forced grant release after this many bytes in one packet, 1..255.

Ports:
- clk  in  1  system clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  NUM_REQ*DATA_BITS  packed bytes; requester i uses bits [i*DATA_BITS +: DATA_BITS].
- req_last  in  NUM_REQ  marks the final byte of a packet; qualified by req_valid.
- req_ready  out  NUM_REQ  one-cycle byte-accept strobe, one-hot or zero.
- grant  out  NUM_REQ  one-hot current owner; zero when idle.
- uart_start  out  1  one-cycle pulse to the transmitter.
- uart_data  out  DATA_BITS  byte presented with uart_start.
- uart_ready  in  1  transmitter idle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous on rst_n low, applies immediately:
  - state=IDLE; grant=0; req_ready=0; uart_start=0; uart_data=0; busy=0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
  - Byte counter = 0.
  - Reset mid-packet abandons the packet. Any byte already handed to the transmitter finishes serially; no retry is made.
- States:
  - IDLE: if any req_valid is set, pick the first valid requester at or after the pointer, wrapping modulo NUM_REQ. Register grant one-hot and go to SEND. Decision to grant takes one cycle.
  - SEND: wait for uart_ready=1 and req_valid[g]=1. In that cycle, all in one clock:
    - uart_start=1 and uart_data=req_data[g].
    - req_ready[g]=1.
    - Byte counter increments.
    - Flag fin = req_last[g] OR (counter+1 == MAX_PKT_BYTES).
    - Go to WAIT_LO.
  - WAIT_LO: wait for uart_ready=0, i.e. the transmitter has taken the byte. Then go to WAIT_HI.
  - WAIT_HI: wait for uart_ready=1.
    - If fin: grant=0, pointer=(g+1) mod NUM_REQ, counter=0, go to IDLE.
    - Else: go to SEND.
- While granted, a requester with req_valid low stalls SEND indefinitely. The grant is not revoked; a bubble is not a packet end.
- Other requesters' req_valid and req_data are ignored while a grant is held.
- A new request arriving in the same cycle the grant is released is arbitrated in the next IDLE cycle.
- uart_start is never asserted while uart_ready=0, and never on two consecutive cycles.
- Minimum byte period: 3 cycles plus the transmitter's frame time.
- Counter width is $clog2(MAX_PKT_BYTES+1). With MAX_PKT_BYTES=1, every byte is its own packet.
- uart_data holds its last value when uart_start=0.

Optional Feature:
- Macro UART_ARB_HDR_EN.
- When defined:
  - After grant, a HDR state sends one header byte before any requester data. Header = {4'hA, granted index} zero-extended or truncated to DATA_BITS.
  - The header follows the same start/WAIT_LO/WAIT_HI handshake.
  - req_ready is not asserted for the header.
  - The header does not count toward MAX_PKT_BYTES.
- When undefined: the HDR state and its logic are absent; grant goes straight to SEND.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum {IDLE, HDR, SEND, WAIT_LO, WAIT_HI}.
  - Header nibble constant HDR_TAG=4'hA.
- One sub-module rr_pick: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot grant and encoded index.
- FSM, counter and datapath live in the top module.

Test Plan:
- Single packet: req0 sends 8'h55, 8'h0F(last); transmitter model with 10-cycle ready-low.
  - Expect exactly two uart_start pulses carrying 55 then 0F, two req_ready[0] strobes, then busy=0.
- Fairness: req1 and req3 hold valid continuously, each sending 1-byte packets.
  - Expect grants in the order 1,3,1,3; never two consecutive grants to the same requester while the other is waiting.
- Packet atomicity: req0 3-byte packet with a 20-cycle valid gap after byte 1, while req2 is valid throughout.
  - Expect grant to stay with requester 0 until its last byte, with no req2 bytes interleaved.
- Cap: MAX_PKT_BYTES=4, req2 streams 6 bytes with no last.
  - Expect grant released after byte 4, then re-granted to finish the remaining 2 bytes.
- Reset mid-packet: pull rst_n low during WAIT_HI.
  - Expect immediately grant=0, busy=0, uart_start=0; after release, the first grant goes to requester 0.
- With UART_ARB_HDR_EN: req3 sends 1 byte 8'hC3.
  - Expect uart_data sequence 8'hA3 then 8'hC3, and exactly one req_ready[3] strobe.
